// File: rtl/pci_target.sv
// -----------------------------------------------------------------------------
// pci_target
//   Minimal 32-bit PCI memory target. It decodes a fixed 32-byte window
//   at BASE_ADDR for memory read (0110) and memory write (0111) commands,
//   backs it with MEM_WORDS words of storage, and supports linear bursts
//   that wrap inside the window. WAIT_STATES extra cycles are inserted
//   before the first TRDY_N of every transaction.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (also clears the storage)
//   FRAME_N   initiator FRAME, active-low
//   IRDY_N    initiator ready, active-low
//   AD_IN     address/data as driven by the initiator
//   C_BE_N    command (address phase) / byte enables, active-low (data phase)
//   AD_OUT    read data, zero whenever not presenting a read word
//   AD_OE     high while this target owns the AD bus
//   DEVSEL_N  device select, active-low
//   TRDY_N    target ready, active-low
// -----------------------------------------------------------------------------
module pci_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          MEM_WORDS   = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        FRAME_N,
  input  logic        IRDY_N,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  C_BE_N,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        DEVSEL_N,
  output logic        TRDY_N
);

  localparam int IW  = $clog2(MEM_WORDS);
  localparam int WCW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

  // Reads need one extra WAIT cycle for the AD turnaround; writes do not.
  localparam logic [WCW-1:0] RD_WAIT = WCW'(WAIT_STATES);
  localparam logic [WCW-1:0] WR_WAIT = (WAIT_STATES > 0) ? WCW'(WAIT_STATES - 1) : '0;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_TURN
  } state_t;

  state_t          state_q, state_d;
  logic            frame_prev_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rd_q, rd_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            mem_we;
  logic [31:0]     mem_q [MEM_WORDS];

  logic addr_phase;
  logic hit;

  // A new address phase is the falling edge of FRAME_N as seen on the clock.
  assign addr_phase = frame_prev_q & ~FRAME_N;
  assign hit        = (AD_IN[31:5] == BASE_ADDR[31:5]) &&
                      ((C_BE_N == CMD_MEM_RD) || (C_BE_N == CMD_MEM_WR));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b1;
      idx_q        <= '0;
      rd_q         <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= FRAME_N;
      idx_q        <= idx_d;
      rd_q         <= rd_d;
      wcnt_q       <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    wcnt_d  = wcnt_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (addr_phase && hit) begin
          idx_d = AD_IN[IW+1:2];
          rd_d  = (C_BE_N == CMD_MEM_RD);
          if ((C_BE_N == CMD_MEM_WR) && (WAIT_STATES == 0)) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = (C_BE_N == CMD_MEM_RD) ? RD_WAIT : WR_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (FRAME_N && IRDY_N) begin
          state_d = S_TURN;            // initiator gave up before any data
        end else if (wcnt_q == '0) begin
          state_d = S_DATA;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (!IRDY_N) begin
          mem_we = ~rd_q;
          idx_d  = idx_q + 1'b1;       // power-of-two depth wraps naturally
          if (FRAME_N) begin
            state_d = S_TURN;
          end
        end else if (FRAME_N) begin
          state_d = S_TURN;            // abandoned while inserting waits
        end
      end

      S_TURN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: cleared by reset, byte-lane masked writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!C_BE_N[b]) begin
          mem_q[idx_q][8*b +: 8] <= AD_IN[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state so reset clears them at once
  // ---------------------------------------------------------------------------
  logic active;
  assign active   = (state_q == S_WAIT) || (state_q == S_DATA);
  assign DEVSEL_N = ~active;
  assign TRDY_N   = ~(state_q == S_DATA);
  assign AD_OE    = active & rd_q;
  assign AD_OUT   = ((state_q == S_DATA) && rd_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_pci_target.sv
module tb_pci_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FRAME_N;
  logic        IRDY_N;
  logic [31:0] AD_IN;
  logic [3:0]  C_BE_N;

  logic [31:0] ad_out0, ad_out2;
  logic        ad_oe0, ad_oe2, devsel0, devsel2, trdy0, trdy2;

  // Which DUT is observed: 0 -> WAIT_STATES=0, 1 -> WAIT_STATES=2
  logic        sel;
  logic [31:0] o_ad_out;
  logic        o_ad_oe, o_devsel_n, o_trdy_n;

  assign o_ad_out   = sel ? ad_out2 : ad_out0;
  assign o_ad_oe    = sel ? ad_oe2  : ad_oe0;
  assign o_devsel_n = sel ? devsel2 : devsel0;
  assign o_trdy_n   = sel ? trdy2   : trdy0;

  pci_target #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .FRAME_N(FRAME_N), .IRDY_N(IRDY_N),
    .AD_IN(AD_IN), .C_BE_N(C_BE_N), .AD_OUT(ad_out0), .AD_OE(ad_oe0),
    .DEVSEL_N(devsel0), .TRDY_N(trdy0)
  );

  pci_target #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .FRAME_N(FRAME_N), .IRDY_N(IRDY_N),
    .AD_IN(AD_IN), .C_BE_N(C_BE_N), .AD_OUT(ad_out2), .AD_OE(ad_oe2),
    .DEVSEL_N(devsel2), .TRDY_N(trdy2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] dat [8];
  logic [3:0]  be  [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl3();
    return {29'd0, o_devsel_n, o_trdy_n, o_ad_oe};
  endfunction

  // One full hit transaction. Write data / expected read data come from dat[],
  // write byte enables from be[]. hold = initiator wait cycles inserted at the
  // first data phase. Returns at the negedge of the TURN cycle.
  task automatic bus_xfer(input string tag, input logic [31:0] addr, input logic rd,
                          input int n, input int hold, input int exp_trdy);
    int cyc, k, h, first_trdy;
    @(negedge clk);
    FRAME_N = 1'b0; IRDY_N = 1'b1; AD_IN = addr;
    C_BE_N  = rd ? 4'b0110 : 4'b0111;
    @(negedge clk);
    cyc = 1;
    check_val({tag, "_devsel"}, {31'd0, o_devsel_n}, 32'd0);
    check_val({tag, "_oe"}, {31'd0, o_ad_oe}, {31'd0, rd});
    AD_IN = 32'd0; C_BE_N = 4'hF;
    k = 0; h = hold; first_trdy = 0;
    while (k < n && cyc < 40) begin
      if (!o_trdy_n) begin
        if (first_trdy == 0) first_trdy = cyc;
        if (h > 0) begin
          IRDY_N = 1'b1;
          h--;
        end else begin
          if (rd) check_val($sformatf("%s_rd%0d", tag, k), o_ad_out, dat[k]);
          else begin
            AD_IN  = dat[k];
            C_BE_N = be[k];
          end
          IRDY_N  = 1'b0;
          FRAME_N = (k == n - 1);
          k++;
        end
      end else begin
        IRDY_N = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < n) check_val({tag, "_timeout"}, k, n);
    check_val({tag, "_trdy_cyc"}, first_trdy, exp_trdy);
    check_val({tag, "_turn"}, ctl3(), 32'd6);
    FRAME_N = 1'b1; IRDY_N = 1'b1; AD_IN = 32'd0; C_BE_N = 4'hF;
    $display("txn %-10s %s addr=%h n=%0d", tag, rd ? "RD" : "WR", addr, n);
  endtask

  // Transaction the target must ignore completely.
  task automatic bus_miss(input string tag, input logic [31:0] addr, input logic [3:0] cmd);
    @(negedge clk);
    FRAME_N = 1'b0; IRDY_N = 1'b1; AD_IN = addr; C_BE_N = cmd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("%s_c%0d", tag, i), ctl3(), 32'd6);
      IRDY_N = 1'b0; AD_IN = 32'hFFFF_FFFF; C_BE_N = 4'h0;
      FRAME_N = (i >= 2);
    end
    FRAME_N = 1'b1; IRDY_N = 1'b1; AD_IN = 32'd0; C_BE_N = 4'hF;
    $display("txn %-10s MISS addr=%h cmd=%b", tag, addr, cmd);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; FRAME_N = 1'b1; IRDY_N = 1'b1; AD_IN = 32'd0; C_BE_N = 4'hF; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ctl0", ctl3(), 32'd6);
    check_val("rst_out0", o_ad_out, 32'd0);
    sel = 1'b1; #1;
    check_val("rst_ctl2", ctl3(), 32'd6);
    sel = 1'b0;
    rst_n = 1'b1;

    // Single write, then a new address phase during TURN must be ignored
    dat[0] = 32'hDEAD_BEEF; be[0] = 4'b0000;
    bus_xfer("wr_single", 32'h104, 1'b0, 1, 0, 1);
    FRAME_N = 1'b0; AD_IN = 32'h104; C_BE_N = 4'b0110;
    @(negedge clk);
    check_val("turn_ign0", ctl3(), 32'd6);
    @(negedge clk);
    check_val("turn_ign1", ctl3(), 32'd6);
    FRAME_N = 1'b1; C_BE_N = 4'hF; AD_IN = 32'd0;
    bus_xfer("rd_single", 32'h104, 1'b1, 1, 0, 2);

    // Byte enables
    dat[0] = 32'h1122_3344; be[0] = 4'b0000;
    bus_xfer("wr_full", 32'h108, 1'b0, 1, 0, 1);
    dat[0] = 32'hAABB_CCDD; be[0] = 4'b1010;
    bus_xfer("wr_bytes", 32'h108, 1'b0, 1, 0, 1);
    dat[0] = 32'h11BB_33DD;
    bus_xfer("rd_bytes", 32'h108, 1'b1, 1, 0, 2);

    // Burst write and burst read wrapping 6 -> 7 -> 0
    dat[0] = 32'hA6; dat[1] = 32'hA7; dat[2] = 32'hA0;
    be[0] = 4'h0; be[1] = 4'h0; be[2] = 4'h0;
    bus_xfer("wr_wrap", 32'h118, 1'b0, 3, 0, 1);
    bus_xfer("rd_wrap", 32'h118, 1'b1, 3, 0, 2);
    dat[0] = 32'hDEAD_BEEF;
    bus_xfer("rd_keep", 32'h104, 1'b1, 1, 0, 2);

    // Initiator waits during a read: index and data hold
    dat[0] = 32'hA6; dat[1] = 32'hA7;
    bus_xfer("rd_irdy", 32'h118, 1'b1, 2, 2, 2);

    // Initiator abandons during WAIT
    @(negedge clk);
    FRAME_N = 1'b0; IRDY_N = 1'b1; AD_IN = 32'h118; C_BE_N = 4'b0110;
    @(negedge clk);
    check_val("abandon_sel", {31'd0, o_devsel_n}, 32'd0);
    FRAME_N = 1'b1; C_BE_N = 4'hF;
    @(negedge clk);
    check_val("abandon_turn", ctl3(), 32'd6);
    $display("txn abandon    RD addr=00000118");

    // Misses: wrong window, wrong command
    bus_miss("miss_addr", 32'h200, 4'b0111);
    bus_miss("miss_cmd", 32'h104, 4'b0010);
    dat[0] = 32'hA0;
    bus_xfer("rd_nomod", 32'h100, 1'b1, 1, 0, 2);

    // Reset in the middle of a read burst
    @(negedge clk);
    FRAME_N = 1'b0; IRDY_N = 1'b1; AD_IN = 32'h118; C_BE_N = 4'b0110;
    @(negedge clk);
    IRDY_N = 1'b0; C_BE_N = 4'h0; AD_IN = 32'd0;
    @(negedge clk);
    check_val("mid_trdy", {31'd0, o_trdy_n}, 32'd0);
    @(negedge clk);
    check_val("mid_data", o_ad_out, 32'hA7);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_ctl", ctl3(), 32'd6);
    check_val("mid_rst_out", o_ad_out, 32'd0);
    FRAME_N = 1'b1; IRDY_N = 1'b1; C_BE_N = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("txn rst_mid    RD addr=00000118 (reset)");
    dat[0] = 32'd0;
    bus_xfer("rd_clr1", 32'h104, 1'b1, 1, 0, 2);
    dat[0] = 32'd0; dat[1] = 32'd0; dat[2] = 32'd0;
    bus_xfer("rd_clr6", 32'h118, 1'b1, 3, 0, 2);

    // WAIT_STATES=2 target: write with initiator waits, then read back
    sel = 1'b1;
    dat[0] = 32'h1234_5678; be[0] = 4'h0;
    bus_xfer("ws2_wr", 32'h10C, 1'b0, 1, 2, 3);
    dat[0] = 32'h1234_5678; dat[1] = 32'd0;
    bus_xfer("ws2_rd", 32'h10C, 1'b1, 2, 0, 4);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0100, decoded memory window base; bits [4:0] SHALL be ignored.
REQ-002 Parameter MEM_WORDS, default 8, number of 32-bit storage words; fixed power of two.
REQ-003 Parameter WAIT_STATES, default 0, extra cycles before the first TRDY_N assertion of a transaction.
REQ-004 clk  input  1  single clock; all sampling on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 FRAME_N  input  1  global bus FRAME, active-low.
REQ-007 IRDY_N  input  1  global bus IRDY, active-low.
REQ-008 AD_IN  input  32  address/data bus value as driven by the initiator.
REQ-009 C_BE_N  input  4  command during the address phase; active-low byte enables during data phases.
REQ-010 AD_OUT  output  32  read data to the bus.
REQ-011 AD_OE  output  1  high while this target drives AD_OUT.
REQ-012 DEVSEL_N  output  1  device select, active-low.
REQ-013 TRDY_N  output  1  target ready, active-low.

Function
REQ-014 An address phase SHALL be the rising edge where FRAME_N=0 and the previous sampled FRAME_N=1, with the FSM in IDLE.
REQ-015 Hit condition: AD_IN[31:5]==BASE_ADDR[31:5], C_BE_N 4'b0110 (memory read) or 4'b0111 (memory write); any other combination SHALL leave all outputs deasserted and the FSM in IDLE.
REQ-016 On a hit, the word index SHALL load AD_IN[log2(MEM_WORDS)+1:2].
REQ-017 States SHALL be IDLE, WAIT, DATA, TURN; there SHALL be no other reachable states.
REQ-018 IDLE->WAIT on a hit; DEVSEL_N SHALL go 0 in the first cycle after the address phase (fast decode).
REQ-019 WAIT SHALL last 1+WAIT_STATES cycles for reads and WAIT_STATES cycles for writes; with a write and WAIT_STATES=0, WAIT is skipped and TRDY_N goes 0 together with DEVSEL_N.
REQ-020 In DATA, TRDY_N SHALL be 0; a data transfer occurs on each edge with IRDY_N=0 and TRDY_N=0.
REQ-021 Write transfer: for each byte lane i with C_BE_N[i]=0, mem[index][8i+7:8i] SHALL take AD_IN[8i+7:8i]; other lanes SHALL be unchanged.
REQ-022 Read: AD_OE SHALL be 1 from the first cycle after the address phase (turnaround) until TURN; AD_OUT SHALL present mem[index] whenever TRDY_N=0.
REQ-023 After each transfer, the index SHALL increment modulo MEM_WORDS (wrap MEM_WORDS-1 -> 0, no disconnect).
REQ-024 IRDY_N=1 during DATA SHALL insert initiator wait states; the index, memory and outputs SHALL hold.
REQ-025 A transfer with FRAME_N=1 is the final one: DATA->TURN; in TURN, DEVSEL_N=1, TRDY_N=1, AD_OE=0; TURN->IDLE after one cycle.
REQ-026 In WAIT or DATA, FRAME_N=1 with IRDY_N=1 (initiator abandoned) SHALL go directly to TURN without a transfer.
REQ-027 A new address phase while in TURN SHALL be ignored; decoding resumes in IDLE.
REQ-028 Memory contents SHALL persist across transactions.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, DEVSEL_N=1, TRDY_N=1, AD_OE=0, AD_OUT=0, index=0, and clear the memory to 0, including mid-transaction.
REQ-030 After rst_n rises, the first address phase SHALL be decoded no earlier than the first full rising edge with rst_n=1.

Verification
REQ-031 Single write: address 0x104, C_BE_N=0111, data 0xDEADBEEF with C_BE_N=0000, FRAME_N deasserted in the same phase -> DEVSEL_N/TRDY_N low one cycle after the address phase; mem[1]=0xDEADBEEF; TURN, then IDLE.
REQ-032 Burst read with wrap: preload mem[6]=0xA6, mem[7]=0xA7, mem[0]=0xA0; read at 0x118 for 3 phases -> AD_OE=1 from cycle 1, TRDY_N low from cycle 2, AD_OUT sequence 0xA6, 0xA7, 0xA0.
REQ-033 Byte enables: mem[2]=0x11223344; write 0xAABBCCDD with C_BE_N=1010 -> mem[2]=0x11BB33DD.
REQ-034 Miss: address 0x200 or command 0010 -> DEVSEL_N, TRDY_N, AD_OE stay deasserted for the whole transaction.
REQ-035 Waits: WAIT_STATES=2, IRDY_N high for 2 cycles in a write phase -> TRDY_N low 2 cycles after DEVSEL_N; exactly one memory write occurs.
REQ-036 Reset mid-burst: rst_n low during a read DATA phase -> all outputs deasserted the same cycle; mem reads 0 afterwards; the next transaction decodes normally.
